// File: rtl/skip3_pkg.sv
// Shared types and sequence-rule helpers for the skip-multiples-of-3 link.
package skip3_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } skip3_state_e;

  // Largest value representable in `width` bits that is not a multiple of 3.
  function automatic logic [31:0] skip3_max(input int unsigned width);
    logic [32:0] full;
    full = (33'd1 << width) - 33'd1;
    if (full % 33'd3 == 33'd0) full = full - 33'd1;
    return full[31:0];
  endfunction

  function automatic logic [31:0] skip3_next(input logic [31:0] v, input logic [31:0] max);
    if (v == max) return '0;
    if ((v + 32'd1) % 32'd3 == 32'd0) return v + 32'd2;
    return v + 32'd1;
  endfunction

  function automatic logic skip3_legal(input logic [31:0] v);
    return (v == '0) || (v % 32'd3 != '0);
  endfunction

endpackage

// File: rtl/skip3_index.sv
// Dense ordinal of a skip-3 counter value: idx(v) = v - floor(v/3).
module skip3_index #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] index_o
);

  always_comb begin
    index_o = value_i - value_i / WIDTH'(3);
  end

endmodule

// File: rtl/skip3_decoder.sv
// Receive-side checker for the skip-3 counter stream: sequence lock FSM,
// dense index conversion and saturating error count, all outputs registered.
module skip3_decoder
  import skip3_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_index,
  output logic             lock,
  output logic             seq_err,
  output logic             ill_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [31:0] MAX32 = skip3_max(WIDTH);

  skip3_state_e     state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [3:0]       run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_index_q, out_index_d;
  logic             seq_err_q, seq_err_d;
  logic             ill_err_q, ill_err_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             legal;
  logic             in_seq;
  logic [WIDTH-1:0] expect_next;
  logic [WIDTH-1:0] idx;

  skip3_index #(.WIDTH(WIDTH)) u_index (
    .value_i (in_count),
    .index_o (idx)
  );

  always_comb begin
    legal       = skip3_legal(32'(in_count));
    expect_next = WIDTH'(skip3_next(32'(ref_q), MAX32));
    in_seq      = (in_count == expect_next);
  end

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    run_d       = run_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    seq_err_d   = 1'b0;
    ill_err_d   = 1'b0;
    err_d       = err_q;

    if (in_valid) begin
      out_valid_d = 1'b1;
      out_index_d = legal ? idx : '0;
      // Illegal values override any sequence judgement and drop lock outright.
      if (!legal) begin
        ill_err_d = 1'b1;
        state_d   = UNLOCKED;
        run_d     = '0;
      end else begin
        ref_d = in_count;
        unique case (state_q)
          UNLOCKED: begin
            run_d   = 4'd1;
            state_d = ACQUIRE;
          end
          ACQUIRE: begin
            if (in_seq) begin
              run_d = run_q + 4'd1;
              if (run_q + 4'd1 == 4'(LOCK_N)) state_d = LOCKED;
            end else begin
              run_d = 4'd1;
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              seq_err_d = 1'b1;
              run_d     = 4'd1;
              state_d   = ACQUIRE;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
      if ((ill_err_d || seq_err_d) && (err_q != '1)) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      ref_q       <= '0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      seq_err_q   <= 1'b0;
      ill_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      seq_err_q   <= seq_err_d;
      ill_err_q   <= ill_err_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_index = out_index_q;
    lock      = (state_q == LOCKED);
    seq_err   = seq_err_q;
    ill_err   = ill_err_q;
    err_cnt   = err_q;
  end

endmodule

// File: tb/tb_skip3_decoder.sv
// Checks skip3_decoder (ERR_W=8 and ERR_W=2 copies) against a list-based
// model of the legal sequence, with directed scenarios then random traffic.
module tb_skip3_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_count = '0;

  logic       a_valid, a_lock, a_seq, a_ill;
  logic [7:0] a_index, a_err;
  logic       b_valid, b_lock, b_seq, b_ill;
  logic [7:0] b_index;
  logic [1:0] b_err;

  always #5 clk = ~clk;

  skip3_decoder #(.WIDTH(8), .LOCK_N(3), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .out_valid(a_valid), .out_index(a_index), .lock(a_lock),
    .seq_err(a_seq), .ill_err(a_ill), .err_cnt(a_err)
  );

  skip3_decoder #(.WIDTH(8), .LOCK_N(3), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .out_valid(b_valid), .out_index(b_index), .lock(b_lock),
    .seq_err(b_seq), .ill_err(b_ill), .err_cnt(b_err)
  );

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The legal values in counting order; a value's index is its position here.
  int pos_of [256];
  int legal_vals [256];
  int n_legal = 0;

  initial begin
    for (int v = 0; v < 256; v++) begin
      if (v == 0 || v % 3 != 0) begin
        pos_of[v] = n_legal;
        legal_vals[n_legal] = v;
        n_legal++;
      end else begin
        pos_of[v] = -1;
      end
    end
  end

  // Model: streak = consecutive in-order samples since the last break.
  int  m_streak = 0;
  bit  m_locked = 0;
  int  m_refpos = 0;
  int  m_errs = 0;
  bit  e_valid = 0, e_seq = 0, e_ill = 0;
  int  e_index = 0;

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_streak = 0; m_locked = 0; m_refpos = 0; m_errs = 0;
      e_valid = 0; e_seq = 0; e_ill = 0; e_index = 0;
    end else if (in_valid) begin
      e_valid = 1; e_seq = 0; e_ill = 0;
      p = pos_of[in_count];
      if (p < 0) begin
        e_ill = 1; e_index = 0; m_streak = 0; m_locked = 0; m_errs++;
      end else begin
        e_index = p;
        if (m_streak == 0) m_streak = 1;
        else if (p == (m_refpos + 1) % n_legal) m_streak++;
        else begin
          if (m_locked) begin e_seq = 1; m_errs++; end
          m_streak = 1; m_locked = 0;
        end
        if (m_streak >= 3) m_locked = 1;
        m_refpos = p;
      end
    end else begin
      e_valid = 0; e_seq = 0; e_ill = 0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("a_valid", a_valid, e_valid);
      chk("a_index", a_index, e_index);
      chk("a_lock",  a_lock,  m_locked);
      chk("a_seq",   a_seq,   e_seq);
      chk("a_ill",   a_ill,   e_ill);
      chk("a_err",   a_err,   (m_errs > 255) ? 255 : m_errs);
      chk("b_index", b_index, e_index);
      chk("b_lock",  b_lock,  m_locked);
      chk("b_flags", {b_valid, b_seq, b_ill}, {e_valid, e_seq, e_ill});
      chk("b_err",   b_err,   (m_errs > 3) ? 3 : m_errs);
    end
  end

  task automatic step(input logic r, input logic v, input logic [7:0] c);
    rst = r; in_valid = v; in_count = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lastpos;
    int r;
    logic [7:0] c;

    step(1'b1, 1'b1, 8'd5);
    step(1'b1, 1'b0, 8'd0);
    checking = 1'b1;
    chk("model_len", n_legal, 171);
    chk("model_idx4", pos_of[4], 3);
    chk("model_idx254", pos_of[254], 170);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_lock", a_lock, 1'b0);
    chk("rst_err", a_err, 8'd0);

    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd1);
    chk("lock_after_2", a_lock, 1'b0);
    step(1'b0, 1'b1, 8'd2);
    chk("lock_after_3", a_lock, 1'b1);
    step(1'b0, 1'b1, 8'd4);
    chk("idx_4", a_index, 8'd3);
    step(1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b1, 8'd7);
    chk("idx_7", a_index, 8'd5);

    step(1'b0, 1'b1, 8'd10);
    chk("seq_10", a_seq, 1'b1);
    chk("unlock_10", a_lock, 1'b0);
    chk("err_10", a_err, 8'd1);
    step(1'b0, 1'b1, 8'd11);
    step(1'b0, 1'b1, 8'd13);
    chk("relock_13", a_lock, 1'b1);

    step(1'b0, 1'b1, 8'd250);
    step(1'b0, 1'b1, 8'd251);
    step(1'b0, 1'b1, 8'd253);
    step(1'b0, 1'b1, 8'd254);
    chk("idx_254", a_index, 8'd170);
    step(1'b0, 1'b1, 8'd0);
    chk("wrap_seq", a_seq, 1'b0);
    chk("wrap_lock", a_lock, 1'b1);
    step(1'b0, 1'b1, 8'd1);

    step(1'b0, 1'b1, 8'd9);
    chk("ill_9", a_ill, 1'b1);
    chk("ill_idx", a_index, 8'd0);
    chk("ill_lock", a_lock, 1'b0);
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b1, 8'd2);
    chk("regain", a_lock, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'($urandom_range(255)));
    chk("gap_idx", a_index, 8'd2);
    step(1'b0, 1'b1, 8'd4);
    chk("gap_lock", a_lock, 1'b1);

    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(3 * i));
    chk("sat_b", b_err, 2'd3);
    chk("cnt_a", a_err, 8'd8);
    step(1'b1, 1'b1, 8'd1);
    chk("rst_all", {a_valid, a_index, a_lock, a_seq, a_ill, a_err}, '0);

    lastpos = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if (r < 2) begin
        step(1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)));
      end else if (r < 12) begin
        step(1'b0, 1'b0, 8'($urandom_range(255)));
      end else begin
        if (r < 20) c = 8'($urandom_range(255));
        else if (r < 24) c = 8'(legal_vals[lastpos]);
        else c = 8'(legal_vals[(lastpos + 1) % n_legal]);
        if (pos_of[c] >= 0) lastpos = pos_of[c];
        step(1'b0, 1'b1, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
